masked_sum_growth: RTL and testbench
====================================

MASKED_SUM_GROWTH -- requirements
Module: masked_sum_growth

Interface
REQ-001 SHALL have parameter NUM_INPUT, default 8: number of input lanes, 2..64.
REQ-002 SHALL have parameter ORI_WIDTH, default 16: signed lane width, 2..64.
REQ-003 SHALL have parameter ACC_MAX, default 16: max beats per accumulation frame, 1..256.
REQ-004 SHALL have OUT_W = ORI_WIDTH + clog2(NUM_INPUT) + clog2(ACC_MAX) and CNT_W = clog2(NUM_INPUT*ACC_MAX+1), derived from the parameters.
REQ-005 SHALL have port i_clk  in  1  clock; reset i_rst_n, synchronous, active-low; clock i_clk.
REQ-006 SHALL have port i_rst_n  in  1  synchronous active-low reset.
REQ-007 SHALL have port i_valid  in  1  input beat valid.
REQ-008 SHALL have port o_ready  out  1  input beat accepted when i_valid and o_ready are both high.
REQ-009 SHALL have port i_data  in  NUM_INPUT*ORI_WIDTH  packed signed lanes, lane k at bits [k*ORI_WIDTH +: ORI_WIDTH].
REQ-010 SHALL have port i_input_enable  in  NUM_INPUT  lane mask; 1 = lane included.
REQ-011 SHALL have port i_acc_len  in  clog2(ACC_MAX+1)  beats per frame.
REQ-012 SHALL have port i_flush  in  1  close the current frame early.
REQ-013 SHALL have port o_valid  out  1  result valid.
REQ-014 SHALL have port i_ready  in  1  result consumed when o_valid and i_ready are both high.
REQ-015 SHALL have port o_sum  out  OUT_W  signed frame sum.
REQ-016 SHALL have port o_count  out  CNT_W  total active lanes in the frame.
REQ-017 SHALL have port o_width  out  8  minimum width that holds o_sum without overflow.

Function
REQ-018 SHALL use a global stall: advance = !o_valid || i_ready; o_ready = advance; no register updates while advance is low.
REQ-019 SHALL in stage 1, on an accepted beat, register the masked, sign-extended lanes (disabled lanes = 0), $countones(mask), a flush flag and a stage-valid flag.
REQ-020 SHALL in stage 2 add the stage-1 lanes with an adder tree, add the result into the frame accumulator, add the popcount into the count accumulator, and increment the beat counter.
REQ-021 SHALL sample i_acc_len on the first beat of each frame; 0 is treated as 1 and values above ACC_MAX are clamped to ACC_MAX.
REQ-022 SHALL close a frame when the beat counter reaches the sampled length, or when a stage-2 beat carries the flush flag.
REQ-023 SHALL on frame close load o_sum and o_count, set o_valid, and clear the accumulators and counter in the same cycle.
REQ-024 SHALL have a latency of 2 cycles from acceptance of the closing beat to o_valid, when not stalled.
REQ-025 SHALL compute o_width = ORI_WIDTH + g, where g = 0 for o_count <= 1, else g = ceil(log2(o_count)); o_width is registered together with o_sum.
REQ-026 SHALL include the beat in the frame and then close the frame when i_flush is high with an accepted beat.
REQ-027 SHALL, when i_flush is high without an accepted beat and the frame is non-empty, close the frame on the next advance cycle, with no added beat.
REQ-028 SHALL ignore i_flush on an empty frame.
REQ-029 SHALL accept the next beat in the same cycle that a result handshake completes.
REQ-030 SHALL never lose or duplicate a beat or result under any i_ready pattern.

Reset
REQ-031 SHALL on reset (i_rst_n low at a clock edge) clear o_valid, o_sum, o_count, the accumulators, the beat counter and the stage-valid flag; o_width resets to ORI_WIDTH.
REQ-032 SHALL discard any partial frame or in-flight beat on reset mid-operation; o_ready is 1 in the first cycle after reset.

Configuration
REQ-033 SHALL, with MASKED_SUM_GROWTH_ACC_EN defined, implement accumulation exactly as REQ-020 to REQ-028.
REQ-034 SHALL, without MASKED_SUM_GROWTH_ACC_EN, close every beat as its own frame; i_acc_len and i_flush are ignored, no accumulator or beat counter is built, and port widths are unchanged.

Structure
REQ-035 SHALL place clog2-derived width functions, the OUT_W/CNT_W helper functions and the growth function in package masked_sum_pkg.
REQ-036 SHALL implement the pipelined lane adder tree in sub-module adder_tree_signed, parameterised by lane count and width.

Verification (NUM_INPUT=8, ORI_WIDTH=16, ACC_MAX=16)
REQ-037 SHALL check reset: after reset, o_valid=0, o_sum=0, o_count=0, o_width=16, o_ready=1.
REQ-038 SHALL check a single beat: acc_len=1, mask=8'h07, all lanes 100 -> 2 cycles later o_sum=300, o_count=3, o_width=18.
REQ-039 SHALL check the negative extreme: acc_len=1, mask=8'hFF, all lanes -32768 -> o_sum=-262144, o_count=8, o_width=19.
REQ-040 SHALL check accumulation: acc_len=4, mask=8'h01, lane0 = 1,2,3,4 -> exactly one result, o_sum=10, o_count=4, o_width=18, with no o_valid before the 4th beat.
REQ-041 SHALL check backpressure: i_ready low for 3 cycles while o_valid is high -> o_sum stable, o_ready=0, the next beat is accepted after release with no loss.
REQ-042 SHALL check flush: acc_len=4, i_flush with the 2nd beat (values 5 and -7, mask=8'h01) -> o_sum=-2, o_count=2, o_width=17; flush on an empty frame -> no output.

Source files
------------

// File: rtl/masked_sum_growth_pkg.sv
// masked_sum_pkg: width helpers and bit-growth function shared by the masked sum datapath
package masked_sum_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return r;
  endfunction

  function automatic int out_w(input int ori, input int num, input int acc);
    return ori + clog2(num) + clog2(acc);
  endfunction

  function automatic int cnt_w(input int num, input int acc);
    return clog2(num * acc + 1);
  endfunction

  function automatic int growth(input int c);
    return (c <= 1) ? 0 : clog2(c);
  endfunction
endpackage

// File: rtl/masked_sum_growth_adder_tree.sv
// adder_tree_signed: balanced binary adder tree over N signed W-bit lanes, full-precision result
module adder_tree_signed
  import masked_sum_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic [N*W-1:0]                lanes,
  output logic signed [W+clog2(N)-1:0]  sum
);
  localparam int SW = W + clog2(N);
  localparam int P  = 1 << clog2(N);

  logic signed [SW-1:0] t [P];

  // sign-extend lanes into a power-of-two leaf row, then fold pairwise level by level
  always_comb begin
    for (int i = 0; i < P; i++) t[i] = '0;
    for (int i = 0; i < N; i++) t[i] = SW'(signed'(lanes[i*W +: W]));
    for (int s = P / 2; s > 0; s = s / 2)
      for (int i = 0; i < s; i++) t[i] = t[2*i] + t[2*i+1];
    sum = t[0];
  end
endmodule

// File: rtl/masked_sum_growth.sv
// masked_sum_growth: masked signed lane sum with bit-growth report; frame accumulation under MASKED_SUM_GROWTH_ACC_EN
module masked_sum_growth
  import masked_sum_pkg::*;
#(
  parameter int NUM_INPUT = 8,
  parameter int ORI_WIDTH = 16,
  parameter int ACC_MAX   = 16
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst_n,
  input  logic                                            i_valid,
  output logic                                            o_ready,
  input  logic [NUM_INPUT*ORI_WIDTH-1:0]                  i_data,
  input  logic [NUM_INPUT-1:0]                            i_input_enable,
  input  logic [clog2(ACC_MAX+1)-1:0]                     i_acc_len,
  input  logic                                            i_flush,
  output logic                                            o_valid,
  input  logic                                            i_ready,
  output logic signed [out_w(ORI_WIDTH,NUM_INPUT,ACC_MAX)-1:0] o_sum,
  output logic [cnt_w(NUM_INPUT,ACC_MAX)-1:0]             o_count,
  output logic [7:0]                                      o_width
);
  localparam int OUT_W = out_w(ORI_WIDTH, NUM_INPUT, ACC_MAX);
  localparam int CNT_W = cnt_w(NUM_INPUT, ACC_MAX);
  localparam int PC_W  = clog2(NUM_INPUT + 1);
  localparam int TS_W  = ORI_WIDTH + clog2(NUM_INPUT);
  localparam int DW    = NUM_INPUT * ORI_WIDTH;

  logic                    advance, close, s1_valid;
  logic [DW-1:0]           masked, s1_lanes;
  logic [PC_W-1:0]         pop, s1_pop;
  logic signed [TS_W-1:0]  ts;
  logic signed [OUT_W-1:0] sum_nx;
  logic [CNT_W-1:0]        cnt_nx;

  assign advance = !o_valid || i_ready;
  assign o_ready = advance;
  assign pop     = PC_W'($countones(i_input_enable));

  // zero the disabled lanes before they enter the pipeline
  always_comb begin
    masked = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      masked[k*ORI_WIDTH +: ORI_WIDTH] = i_input_enable[k] ? i_data[k*ORI_WIDTH +: ORI_WIDTH] : '0;
  end

`ifdef MASKED_SUM_GROWTH_ACC_EN
  localparam int LEN_W = clog2(ACC_MAX + 1);

  logic                    s1_flush;
  logic [LEN_W-1:0]        len_in, s1_len, len_q, flen, beats, beats_nx;
  logic signed [OUT_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  assign len_in = (i_acc_len == '0) ? LEN_W'(1) :
                  (i_acc_len > LEN_W'(ACC_MAX)) ? LEN_W'(ACC_MAX) : i_acc_len;

  // stage 1: capture the beat; a flush with no beat travels as an empty flush token
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_flush <= 1'b0;
      s1_lanes <= '0;
      s1_pop   <= '0;
      s1_len   <= '0;
    end else if (advance) begin
      s1_valid <= i_valid;
      s1_flush <= i_flush;
      s1_lanes <= masked;
      s1_pop   <= pop;
      s1_len   <= len_in;
    end
  end

  assign flen     = (beats == '0) ? s1_len : len_q;
  assign beats_nx = beats + 1'b1;
  assign sum_nx   = acc + (s1_valid ? OUT_W'(ts) : '0);
  assign cnt_nx   = cnt + (s1_valid ? CNT_W'(s1_pop) : '0);
  assign close    = s1_valid ? (beats_nx == flen || s1_flush) : (s1_flush && beats != '0);

  // stage 2 frame state: accumulate each beat, start afresh when the frame closes
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      beats <= '0;
      len_q <= '0;
    end else if (advance) begin
      if (close) begin
        acc   <= '0;
        cnt   <= '0;
        beats <= '0;
      end else if (s1_valid) begin
        acc   <= sum_nx;
        cnt   <= cnt_nx;
        beats <= beats_nx;
        len_q <= flen;
      end
    end
  end
`else
  logic unused;

  assign unused = ^{i_flush, i_acc_len};

  // stage 1: capture the beat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_lanes <= '0;
      s1_pop   <= '0;
    end else if (advance) begin
      s1_valid <= i_valid;
      s1_lanes <= masked;
      s1_pop   <= pop;
    end
  end

  assign sum_nx = OUT_W'(ts);
  assign cnt_nx = CNT_W'(s1_pop);
  assign close  = s1_valid;
`endif

  adder_tree_signed #(.N(NUM_INPUT), .W(ORI_WIDTH)) u_tree (
    .lanes (s1_lanes),
    .sum   (ts)
  );

  // result register: load on frame close, drop valid once the result is taken
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_count <= '0;
      o_width <= 8'(ORI_WIDTH);
    end else if (advance) begin
      o_valid <= close;
      if (close) begin
        o_sum   <= sum_nx;
        o_count <= cnt_nx;
        o_width <= 8'(ORI_WIDTH + growth(int'(cnt_nx)));
      end
    end
  end
endmodule

// File: tb/tb_masked_sum_growth.sv
// tb_masked_sum_growth: directed self-checking bench for masked_sum_growth at 8 lanes x 16 bits, ACC_MAX 16
module tb_masked_sum_growth;
  logic               clk, rst_n, in_valid, out_ready, flush, out_valid, rdy;
  logic [127:0]       data;
  logic [7:0]         en, cnt, width;
  logic [4:0]         len;
  logic signed [22:0] sum;
  int                 total, bad;

  masked_sum_growth #(.NUM_INPUT(8), .ORI_WIDTH(16), .ACC_MAX(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (in_valid),
    .o_ready        (out_ready),
    .i_data         (data),
    .i_input_enable (en),
    .i_acc_len      (len),
    .i_flush        (flush),
    .o_valid        (out_valid),
    .i_ready        (rdy),
    .o_sum          (sum),
    .o_count        (cnt),
    .o_width        (width)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] fill(input int v);
    logic [15:0] x;
    x = 16'(v);
    return {8{x}};
  endfunction

  function automatic logic [127:0] l0(input int v);
    logic [15:0] x;
    x = 16'(v);
    return {112'd0, x};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic res(input string tag, input int s, input int c, input int w);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, sum, s);
    chk({tag, "_count"}, 64'(cnt), c);
    chk({tag, "_width"}, 64'(width), w);
  endtask

  task automatic send(input logic [127:0] d, input logic [7:0] m, input logic [4:0] l, input logic f);
    in_valid = 1'b1;
    data = d;
    en = m;
    len = l;
    flush = f;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rdy = 1'b1;
    in_valid = 1'b0;
    data = '0;
    en = '0;
    len = 5'd1;
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", sum, 0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_width", 64'(width), 64'd16);
    chk("rst_ready", 64'(out_ready), 64'd1);

    send(fill(100), 8'h07, 5'd1, 1'b0);
    chk("single_lat", 64'(out_valid), 64'd0);
    step();
    res("single", 300, 3, 18);
    step();
    chk("single_clr", 64'(out_valid), 64'd0);

    send(fill(-32768), 8'hFF, 5'd1, 1'b0);
    step();
    res("neg", -262144, 8, 19);
    step();

    send(fill(1), 8'h0F, 5'd0, 1'b0);
    step();
    res("len0", 4, 4, 18);
    step();

`ifdef MASKED_SUM_GROWTH_ACC_EN
    for (int k = 1; k <= 4; k++) begin
      send(l0(k), 8'h01, 5'd4, 1'b0);
      chk("acc_early", 64'(out_valid), 64'd0);
    end
    step();
    res("acc", 10, 4, 18);
    step();
    chk("acc_once", 64'(out_valid), 64'd0);
    step();
    chk("acc_once2", 64'(out_valid), 64'd0);

    for (int k = 0; k < 16; k++) send(l0(1), 8'h01, 5'd31, 1'b0);
    chk("clamp_early", 64'(out_valid), 64'd0);
    step();
    res("clamp", 16, 16, 20);
    step();
`else
    for (int k = 1; k <= 4; k++) begin
      send(l0(k), 8'h01, 5'd4, 1'b0);
      step();
      res("beat", k, 1, 16);
      step();
    end
    chk("beat_clr", 64'(out_valid), 64'd0);
`endif

    rdy = 1'b0;
    send(fill(1), 8'hFF, 5'd1, 1'b0);
    step();
    res("bp0", 8, 8, 19);
    in_valid = 1'b1;
    data = fill(2);
    en = 8'h03;
    len = 5'd1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready", 64'(out_ready), 64'd0);
      res("bp_hold", 8, 8, 19);
    end
    rdy = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(out_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_clr", 64'(out_valid), 64'd0);
    step();
    res("bp1", 4, 2, 17);
    step();
    chk("bp_done", 64'(out_valid), 64'd0);

`ifdef MASKED_SUM_GROWTH_ACC_EN
    send(l0(5), 8'h01, 5'd4, 1'b0);
    chk("fl_early", 64'(out_valid), 64'd0);
    send(l0(-7), 8'h01, 5'd4, 1'b1);
    chk("fl_early2", 64'(out_valid), 64'd0);
    step();
    res("flush", -2, 2, 17);
    step();
    chk("flush_clr", 64'(out_valid), 64'd0);

    send(l0(9), 8'h01, 5'd4, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("tok_early", 64'(out_valid), 64'd0);
    step();
    res("flush_tok", 9, 1, 16);
    step();
`else
    send(l0(5), 8'h01, 5'd4, 1'b0);
    send(l0(-7), 8'h01, 5'd4, 1'b1);
    res("nf1", 5, 1, 16);
    step();
    res("nf2", -7, 1, 16);
    step();
`endif

    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("flush_empty", 64'(out_valid), 64'd0);
    end

    send(l0(3), 8'h01, 5'd4, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(out_ready), 64'd1);
    chk("mrst_sum", sum, 0);
    send(l0(1), 8'h01, 5'd1, 1'b0);
    step();
    res("post_rst", 1, 1, 16);
    step();
    chk("post_rst_clr", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
